clkdiv_multi: RTL and testbench
===============================

// Module: clkdiv_multi
// PURPOSE
//  N-channel programmable clock-enable/divider generator; successor to the fixed single-ratio divider.
//  Each channel has a runtime-loadable divisor, its own enable and a 1-cycle tick strobe.
//  Divisor changes take effect only at a period boundary, so no runt pulses occur.
//  Sits beside the debouncer at top level and feeds UART bit clocks, LED blink and peripheral strobes.
// PARAMETERS
//  CHANNELS     4   number of independent divider channels (>=1)
//  CNT_W        32  width of divisor/counter; divisor range 2..2**CNT_W-1
//  DEFAULT_DIV  50  divisor loaded into every channel at reset (>=2)
// PORTS
//  clock     in   1                    system clock; all state on rising edge
//  reset     in   1                    asynchronous, active-high reset
//  ckena     in   1                    global advance enable; 0 freezes all channels
//  ch_en     in   CHANNELS             per-channel run enable
//  div_wr    in   1                    1-cycle write strobe for div_val into channel div_sel
//  div_sel   in   $clog2(CHANNELS)>=1  target channel of write; out-of-range index ignored
//  div_val   in   CNT_W                new divisor (period in clock cycles)
//  ckout     out  CHANNELS             divided square wave per channel
//  tick      out  CHANNELS             1-cycle strobe at start of each period
// BEHAVIOUR
//  - Per channel: per (active divisor), pend + pend_v (pending divisor), cnt (0..per-1); all registered.
//  - Reset: per=DEFAULT_DIV, pend_v=0, cnt=per-1 (parked), ckout=0, tick=0; async assert, sync use after release.
//  - div_val<2 clamped to 2 on write. Writes to same channel before boundary: last one wins.
//  - Running (ch_en=1, ckena=1): cnt <= (cnt==per-1) ? 0 : cnt+1.
//    On wrap: if pend_v then per<=pend, pend_v<=0; new period starts with new per.
//  - ckout registered with cnt: ckout=1 iff channel running and new cnt < per/2 (floor) using the
//    per valid for that period -> D=4: 1100, D=5: 11000, D=2: 10.
//  - tick=1 exactly in cycle after the edge where cnt wrapped to 0; never during freeze.
//  - ckena=0: cnt, ckout, per frozen; tick=0; writes still captured into pend.
//  - ch_en=0: next edge cnt parked at per-1, ckout=0, tick=0; a write to a disabled channel
//    loads per directly (pend_v cleared). First enabled+ckena edge wraps to 0 -> tick=1, ckout=1.
//  - div_wr coincident with wrap edge on same channel: write goes to pend, applied at the following wrap.
//  - Latency: write -> effect at next boundary (<=per cycles); enable -> first tick 1 edge.
// CONFIGURATION
//  CLKDIV_DUTY_EN defined: extra input duty_val[CNT_W], captured with div_wr into pend_hi/hi (same
//    boundary rules); ckout=1 iff cnt < min(hi,per); hi=0 -> ckout held 0, hi>=per -> held 1.
//    Reset hi=DEFAULT_DIV/2.
//  CLKDIV_DUTY_EN undefined: no duty_val port; high time fixed at floor(per/2).
// STRUCTURE
//  clkdiv_pkg: typedef logic [CNT_W-1:0] cnt_t (parametrised via localparam in module),
//    localparam MIN_DIV=2, function clamp_div(cnt_t) returning max(v,MIN_DIV).
//  Sub-module clkdiv_chan: one channel (cnt/per/pend/hi regs, ckout/tick); clkdiv_multi decodes
//    div_wr/div_sel into per-channel write strobes and generates CHANNELS instances.
// TESTING  (CHANNELS=4, CNT_W=16, DEFAULT_DIV=4)
//  1 reset release, ckena=1, ch_en=4'hF -> every ckout 1100 repeating, tick on first edge then every 4.
//  2 ch2 at cnt=1 write 6 then 8 -> current 4-cycle period completes, then 11110000, 6 never used.
//  3 write 1 to ch0 -> clamped: ckout 1010..., tick every 2 cycles from next boundary.
//  4 ckena=0 for 3 cycles mid-period -> no ticks, ckout/cnt frozen, resume at same phase.
//  5 ch_en[1]=0 -> ckout[1]=0 next edge; write 5; re-enable -> tick+ckout high first edge, 11000.
//  6 assert reset mid-period -> ckout/tick 0 immediately; after release period back to 4.
//  7 (CLKDIV_DUTY_EN) write div 5, duty 1 -> 10000; duty 0 -> ckout low, ticks continue.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and divisor clamp helper for the multi-channel clock divider.
// Widths vary per instance, so the helper works on a wide carrier type.
package clkdiv_pkg;

    localparam int MIN_DIV = 2;
    localparam int WIDE_W  = 64;

    typedef logic [WIDE_W-1:0] wide_t;

    function automatic wide_t clamp_div(wide_t v);
        return (v < wide_t'(MIN_DIV)) ? wide_t'(MIN_DIV) : v;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Control/status bundle of clkdiv_multi. CLKDIV_DUTY_EN adds the duty_val field.
interface clkdiv_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                ckena;
    logic [CHANNELS-1:0] ch_en;
    logic                div_wr;
    logic [SEL_W-1:0]    div_sel;
    logic [CNT_W-1:0]    div_val;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0]    duty_val;
`endif
    logic [CHANNELS-1:0] ckout;
    logic [CHANNELS-1:0] tick;

`ifdef CLKDIV_DUTY_EN
    modport master (output ckena, ch_en, div_wr, div_sel, div_val, duty_val,
                    input  ckout, tick);
    modport slave  (input  ckena, ch_en, div_wr, div_sel, div_val, duty_val,
                    output ckout, tick);
`else
    modport master (output ckena, ch_en, div_wr, div_sel, div_val,
                    input  ckout, tick);
    modport slave  (input  ckena, ch_en, div_wr, div_sel, div_val,
                    output ckout, tick);
`endif

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: active/pending divisor, period counter, registered ckout and tick.
// CLKDIV_DUTY_EN adds a programmable high time (hi) with the same boundary rules as per.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ckena_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] val_i,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0] duty_i,
`endif
    output logic             ckout_o,
    output logic             tick_o
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEF_PER = cnt_t'(DEFAULT_DIV);

    cnt_t per_q, pend_q, cnt_q;
    logic pend_v_q, ckout_q, tick_q;
    cnt_t wval, per_nxt, cnt_inc, thr_cur, thr_nxt;
    logic wrap;

`ifdef CLKDIV_DUTY_EN
    localparam cnt_t DEF_HI = cnt_t'(DEFAULT_DIV / 2);
    cnt_t hi_q, pend_hi_q, hi_nxt;
`endif

    always_comb begin
        wval    = cnt_t'(clamp_div(wide_t'(val_i)));
        wrap    = (cnt_q == per_q - cnt_t'(1));
        cnt_inc = cnt_q + cnt_t'(1);
        per_nxt = pend_v_q ? pend_q : per_q;
`ifdef CLKDIV_DUTY_EN
        hi_nxt  = pend_v_q ? pend_hi_q : hi_q;
        thr_cur = (hi_q < per_q) ? hi_q : per_q;
        thr_nxt = (hi_nxt < per_nxt) ? hi_nxt : per_nxt;
`else
        thr_cur = per_q >> 1;
        thr_nxt = per_nxt >> 1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_q     <= DEF_PER;
            pend_q    <= DEF_PER;
            pend_v_q  <= 1'b0;
            cnt_q     <= DEF_PER - cnt_t'(1);
            ckout_q   <= 1'b0;
            tick_q    <= 1'b0;
`ifdef CLKDIV_DUTY_EN
            hi_q      <= DEF_HI;
            pend_hi_q <= DEF_HI;
`endif
        end else if (!en_i) begin
            // Disabled: park one short of wrap so re-enable starts a fresh period at once.
            tick_q  <= 1'b0;
            ckout_q <= 1'b0;
            if (wr_i) begin
                per_q    <= wval;
                pend_v_q <= 1'b0;
                cnt_q    <= wval - cnt_t'(1);
`ifdef CLKDIV_DUTY_EN
                hi_q     <= duty_i;
`endif
            end else begin
                cnt_q <= per_q - cnt_t'(1);
            end
        end else begin
            if (!ckena_i) begin
                tick_q <= 1'b0;
            end else if (wrap) begin
                cnt_q    <= '0;
                per_q    <= per_nxt;
                pend_v_q <= 1'b0;
                ckout_q  <= (thr_nxt != '0);
                tick_q   <= 1'b1;
`ifdef CLKDIV_DUTY_EN
                hi_q     <= hi_nxt;
`endif
            end else begin
                cnt_q   <= cnt_inc;
                ckout_q <= (cnt_inc < thr_cur);
                tick_q  <= 1'b0;
            end
            // A write on the wrap edge lands in pend and waits for the next boundary.
            if (wr_i) begin
                pend_q    <= wval;
                pend_v_q  <= 1'b1;
`ifdef CLKDIV_DUTY_EN
                pend_hi_q <= duty_i;
`endif
            end
        end
    end

    assign ckout_o = ckout_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// N-channel programmable clock-enable/divider: decodes divisor writes, one clkdiv_chan per channel.
// Optional CLKDIV_DUTY_EN adds a per-channel programmable high time.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50
) (
    input  logic          clock,
    input  logic          reset,
    clkdiv_multi_if.slave bus
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] wr_vec;
    logic [CHANNELS-1:0] ckout_w;
    logic [CHANNELS-1:0] tick_w;

    // Indices past CHANNELS-1 match nothing, so such writes are dropped.
    always_comb begin
        wr_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.div_wr && (bus.div_sel == SEL_W'(i))) wr_vec[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .ckena_i (bus.ckena),
            .en_i    (bus.ch_en[g]),
            .wr_i    (wr_vec[g]),
            .val_i   (bus.div_val),
`ifdef CLKDIV_DUTY_EN
            .duty_i  (bus.duty_val),
`endif
            .ckout_o (ckout_w[g]),
            .tick_o  (tick_w[g])
        );
    end

    assign bus.ckout = ckout_w;
    assign bus.tick  = tick_w;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi (4 channels, 16-bit, default divisor 4) with an expectation queue.
module tb_clkdiv_multi;

    localparam int CH = 4;
    localparam int CW = 16;

    typedef struct {
        int         tag;
        logic [3:0] mask;
        logic [3:0] ck;
        logic [3:0] tk;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    clkdiv_multi_if #(.CHANNELS(CH), .CNT_W(CW), .SEL_W(2)) bus ();

    clkdiv_multi #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk_now(input logic [3:0] eck, input logic [3:0] etk);
        total++;
        assert (bus.ckout === eck) else begin
            bad++;
            $error("FAIL ckout_async tag=%0d got=%h exp=%h", tag, bus.ckout, eck);
        end
        total++;
        assert (bus.tick === etk) else begin
            bad++;
            $error("FAIL tick_async tag=%0d got=%h exp=%h", tag, bus.tick, etk);
        end
    endtask

    // Queue the expectation for the coming edge, then compare just after it.
    task automatic cyc(input logic [3:0] m, input logic [3:0] eck, input logic [3:0] etk);
        exp_t e;
        sb.push_back('{tag, m, eck, etk});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        total++;
        assert ((bus.ckout & e.mask) === (e.ck & e.mask)) else begin
            bad++;
            $error("FAIL ckout tag=%0d got=%h exp=%h mask=%h", e.tag, bus.ckout, e.ck, e.mask);
        end
        total++;
        assert ((bus.tick & e.mask) === (e.tk & e.mask)) else begin
            bad++;
            $error("FAIL tick tag=%0d got=%h exp=%h mask=%h", e.tag, bus.tick, e.tk, e.mask);
        end
        tag++;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [CW-1:0] val, input logic [CW-1:0] duty);
        bus.div_wr  = 1'b1;
        bus.div_sel = sel;
        bus.div_val = val;
`ifdef CLKDIV_DUTY_EN
        bus.duty_val = duty;
`else
        if (duty != '0) bus.div_val = val;
`endif
    endtask

    task automatic wr_off();
        bus.div_wr = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.ckena   = 1'b1;
        bus.ch_en   = 4'hF;
        bus.div_wr  = 1'b0;
        bus.div_sel = '0;
        bus.div_val = '0;
`ifdef CLKDIV_DUTY_EN
        bus.duty_val = '0;
`endif
        #3;
        chk_now(4'h0, 4'h0);
        #9 reset = 1'b0;

        // 1: default divisor 4 on all channels, 1100 pattern, tick on first edge
        repeat (2) begin
            cyc(4'hF, 4'hF, 4'hF); cyc(4'hF, 4'hF, 4'h0);
            cyc(4'hF, 4'h0, 4'h0); cyc(4'hF, 4'h0, 4'h0);
        end

        // 2: ch2 gets 6 then 8 mid-period; only 8 takes effect at the boundary
        cyc(4'hF, 4'hF, 4'hF);
        wr(2'd2, 16'd6, 16'd3);
        cyc(4'hF, 4'hF, 4'h0);
        wr(2'd2, 16'd8, 16'd4);
        cyc(4'hF, 4'h0, 4'h0);
        wr_off();
        cyc(4'hF, 4'h0, 4'h0);
        cyc(4'hF, 4'hF, 4'hF); cyc(4'hF, 4'hF, 4'h0);
        cyc(4'hF, 4'h4, 4'h0); cyc(4'hF, 4'h4, 4'h0);
        cyc(4'hF, 4'hB, 4'hB); cyc(4'hF, 4'hB, 4'h0);
        cyc(4'hF, 4'h0, 4'h0); cyc(4'hF, 4'h0, 4'h0);
        cyc(4'hF, 4'hF, 4'hF);

        // 3: divisor 1 on ch0 clamps to 2
        wr(2'd0, 16'd1, 16'd1);
        cyc(4'hF, 4'hF, 4'h0);
        wr_off();
        cyc(4'hF, 4'h4, 4'h0); cyc(4'hF, 4'h4, 4'h0);
        cyc(4'hF, 4'hB, 4'hB); cyc(4'hF, 4'hA, 4'h0);
        cyc(4'hF, 4'h1, 4'h1); cyc(4'hF, 4'h0, 4'h0);
        cyc(4'hF, 4'hF, 4'hF);

        // 4: freeze three edges mid-period, then resume at the same phase
        cyc(4'hF, 4'hE, 4'h0);
        bus.ckena = 1'b0;
        repeat (3) cyc(4'hF, 4'hE, 4'h0);
        bus.ckena = 1'b1;
        cyc(4'hF, 4'h5, 4'h1); cyc(4'hF, 4'h4, 4'h0);
        cyc(4'hF, 4'hB, 4'hB);

        // 5: disable ch1, load 5 while disabled, re-enable -> 11000
        bus.ch_en = 4'hD;
        cyc(4'hF, 4'h8, 4'h0);
        wr(2'd1, 16'd5, 16'd2);
        cyc(4'hF, 4'h1, 4'h1);
        wr_off();
        bus.ch_en = 4'hF;
        cyc(4'hF, 4'h2, 4'h2); cyc(4'hF, 4'hF, 4'hD);
        cyc(4'hF, 4'hC, 4'h0); cyc(4'hF, 4'h5, 4'h1);
        cyc(4'hF, 4'h4, 4'h0); cyc(4'hF, 4'hB, 4'hB);

        // 6: asynchronous reset mid-period clears outputs at once; divisors back to 4
        #2 reset = 1'b1;
        #1 chk_now(4'h0, 4'h0);
        #1 reset = 1'b0;
        cyc(4'hF, 4'hF, 4'hF); cyc(4'hF, 4'hF, 4'h0);
        cyc(4'hF, 4'h0, 4'h0); cyc(4'hF, 4'h0, 4'h0);
        cyc(4'hF, 4'hF, 4'hF);

`ifdef CLKDIV_DUTY_EN
        // 7: ch3 divisor 5 with duty 1, then duty 0 keeps ticks but holds ckout low
        wr(2'd3, 16'd5, 16'd1);
        cyc(4'h8, 4'h8, 4'h0);
        wr_off();
        cyc(4'h8, 4'h0, 4'h0); cyc(4'h8, 4'h0, 4'h0);
        cyc(4'h8, 4'h8, 4'h8);
        repeat (4) cyc(4'h8, 4'h0, 4'h0);
        cyc(4'h8, 4'h8, 4'h8);
        wr(2'd3, 16'd5, 16'd0);
        cyc(4'h8, 4'h0, 4'h0);
        wr_off();
        repeat (3) cyc(4'h8, 4'h0, 4'h0);
        cyc(4'h8, 4'h0, 4'h8);
        repeat (4) cyc(4'h8, 4'h0, 4'h0);
        cyc(4'h8, 4'h0, 4'h8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
